// File: rtl/cpu_seq_ctrl_if.sv
// Control bus between the sequencer and the accumulator datapath.
// master = sequencer side, slave = datapath/memory side.
interface cpu_seq_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] pc_ctrl;
  logic       mar_load;
  logic       mar_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_load;
  logic       mbr_load;
  logic       acc_load;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       halted;
  logic       illegal;
  logic       bus_err;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_ctrl, mar_load, mar_sel,
    output mem_rd, mem_wr,
    output ir_load, mbr_load, acc_load,
    output alu_op, instr_done,
    output halted, illegal, bus_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_ctrl, mar_load, mar_sel,
    input  mem_rd, mem_wr,
    input  ir_load, mbr_load, acc_load,
    input  alu_op, instr_done,
    input  halted, illegal, bus_err
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Strobes decode from the registered state; halts on bad opcode or timeout.
module cpu_seq_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 4
) (
  input  logic           clk,
  input  logic           rst,
  cpu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH_A, FETCH_R, DECODE, OPER_A,
    OPER_R, EXEC, MEM, HALT
  } state_t;

  localparam logic [WAIT_W-1:0] LIMIT =
    WAIT_W'(WAIT_LIMIT);

  state_t            state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic              halted_q, illegal_q, bus_err_q;
  logic              in_wait, timeout, set_ill;
  logic              is_nop, is_oper, is_halt;
  logic              is_jmp, is_jz, is_store;
  logic              is_add, is_sub;

  assign is_nop   = bus.opcode == 4'h0;
  assign is_store = bus.opcode == 4'h2;
  assign is_add   = bus.opcode == 4'h3;
  assign is_sub   = bus.opcode == 4'h4;
  assign is_jmp   = bus.opcode == 4'h5;
  assign is_jz    = bus.opcode == 4'h6;
  assign is_halt  = bus.opcode == 4'hF;
  assign is_oper  = bus.opcode >= 4'h1 &&
                    bus.opcode <= 4'h6;

  assign in_wait = state inside {FETCH_R, OPER_R, MEM};
  assign timeout = in_wait && !bus.mem_ready &&
                   cnt == LIMIT;

  // Wait counter restarts whenever a wait state is (re)entered.
  assign cnt_n = (in_wait && !bus.mem_ready && !timeout)
               ? cnt + 1'b1 : '0;

  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;

  // State register, wait counter and sticky halt causes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_A;
      cnt       <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state_n == HALT) halted_q  <= 1'b1;
      if (set_ill)         illegal_q <= 1'b1;
      if (timeout)         bus_err_q <= 1'b1;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_n        = state;
    set_ill        = 1'b0;
    bus.pc_ctrl    = 2'b00;
    bus.mar_load   = 1'b0;
    bus.mar_sel    = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_load    = 1'b0;
    bus.mbr_load   = 1'b0;
    bus.acc_load   = 1'b0;
    bus.alu_op     = 2'b00;
    bus.instr_done = 1'b0;
    unique case (state)
      FETCH_A: begin
        bus.mar_load = 1'b1;
        state_n      = FETCH_R;
      end
      FETCH_R: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load = 1'b1;
          bus.pc_ctrl = 2'b01;
          state_n     = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_nop: begin
            bus.instr_done = 1'b1;
            state_n        = FETCH_A;
          end
          is_oper: state_n = OPER_A;
          is_halt: state_n = HALT;
          default: begin
            set_ill = 1'b1;
            state_n = HALT;
          end
        endcase
      end
      OPER_A: begin
        bus.mar_load = 1'b1;
        state_n      = OPER_R;
      end
      OPER_R: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          bus.mbr_load = 1'b1;
          bus.pc_ctrl  = 2'b01;
          state_n      = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          is_jmp: begin
            bus.pc_ctrl    = 2'b10;
            bus.instr_done = 1'b1;
            state_n        = FETCH_A;
          end
          is_jz: begin
            bus.pc_ctrl    = bus.zero ? 2'b10 : 2'b00;
            bus.instr_done = 1'b1;
            state_n        = FETCH_A;
          end
          default: begin
            bus.mar_sel  = 1'b1;
            bus.mar_load = 1'b1;
            state_n      = MEM;
          end
        endcase
      end
      MEM: begin
        bus.mem_wr = is_store;
        bus.mem_rd = !is_store;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          bus.acc_load   = !is_store;
          bus.alu_op     = is_add ? 2'b01 :
                           is_sub ? 2'b10 : 2'b00;
          state_n        = FETCH_A;
        end
      end
      HALT: state_n = HALT;
    endcase
    if (timeout) state_n = HALT;
    if (rst) begin
      bus.pc_ctrl    = 2'b00;
      bus.mar_load   = 1'b0;
      bus.mar_sel    = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.ir_load    = 1'b0;
      bus.mbr_load   = 1'b0;
      bus.acc_load   = 1'b0;
      bus.alu_op     = 2'b00;
      bus.instr_done = 1'b0;
    end
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Drives the program counter's 2-bit control, MAR load and source select, memory read/write strobes, IR/MBR/ACC load enables and ALU op.
- Waits on a memory-ready handshake and halts on an illegal opcode or a memory timeout.
- Sits between the IR/flag outputs of the datapath and every datapath load enable.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles a memory access may wait for mem_ready before bus error.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  4  IR[7:4], valid from the cycle after ir_load.
- zero  in  1  accumulator zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_ctrl  out  2  PC command: 00 hold, 01 increment, 10 load from MBR, 11 never driven.
- mar_load  out  1  load MAR.
- mar_sel  out  1  MAR source: 0 = PC, 1 = MBR.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- ir_load  out  1  capture read data into IR.
- mbr_load  out  1  capture read data into MBR.
- acc_load  out  1  load ACC from ALU result.
- alu_op  out  2  ALU op: 00 pass, 01 add, 10 sub.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- halted  out  1  registered; sequencer stopped.
- illegal  out  1  registered; halt cause was an undefined opcode.
- bus_err  out  1  registered; halt cause was a memory timeout.

Behaviour:
- Reset: rst=1 at a clock edge sets state to FETCH_A and clears the wait counter, halted, illegal and bus_err. While rst=1, all strobes are forced to 0 and pc_ctrl to 00. Reset mid-access abandons the access with no write.
- Strobes are decoded combinationally from the registered state, plus mem_ready and zero where noted. Every strobe not listed for a state is 0.
- Opcodes:
  - 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 JMP, 6 JZ, F HALT.
  - 1-6 take one operand byte, which is the address or jump target.
  - 7-E are illegal.
- FETCH_A: mar_sel=0, mar_load=1. Next state is FETCH_R.
- FETCH_R: mem_rd=1.
  - mem_ready=1: ir_load=1, pc_ctrl=01, go to DECODE.
  - mem_ready=0: stay.
- DECODE:
  - NOP: instr_done=1, go to FETCH_A.
  - 1-6: go to OPER_A.
  - F: go to HALT.
  - Illegal: set illegal, go to HALT.
- OPER_A: mar_sel=0, mar_load=1. Next state is OPER_R.
- OPER_R: mem_rd=1.
  - mem_ready=1: mbr_load=1, pc_ctrl=01, go to EXEC.
  - mem_ready=0: stay.
- EXEC:
  - JMP: pc_ctrl=10, instr_done=1, go to FETCH_A.
  - JZ: pc_ctrl=10 if zero=1, otherwise 00; instr_done=1, go to FETCH_A.
  - LOAD/STORE/ADD/SUB: mar_sel=1, mar_load=1, go to MEM.
- MEM:
  - LOAD/ADD/SUB: mem_rd=1. When mem_ready=1: acc_load=1, alu_op = 00/01/10 respectively, instr_done=1, go to FETCH_A.
  - STORE: mem_wr=1. When mem_ready=1: instr_done=1, go to FETCH_A.
- HALT: halted=1 (registered on entry), all strobes 0. Only rst exits.
- Wait counter:
  - Clears on entry to FETCH_R, OPER_R and MEM.
  - Increments each cycle in those states while mem_ready=0.
  - If mem_ready=0 when the count equals WAIT_LIMIT, set bus_err and go to HALT; no load strobe is asserted that cycle.
  - mem_ready=1 on the cycle the count reaches WAIT_LIMIT counts as success.
- Zero-wait latency:
  - NOP: 3 cycles.
  - HALT: 3 cycles to the halted state.
  - JMP/JZ: 6 cycles.
  - LOAD/STORE/ADD/SUB: 7 cycles.
- Each wait cycle adds 1 to the instruction's latency.
- mem_rd and mem_wr are never asserted together. pc_ctrl is never 11.
- The opcode is sampled only in DECODE, EXEC and MEM; opcode changes in other states are ignored.

Test Plan:
- Reset, then NOP stream with mem_ready tied 1 -> pc_ctrl=01 once every 3 cycles; instr_done pulses on cycles 3, 6, 9; strobes 0 during reset.
- LOAD 0x40, mem_ready=1 -> 7 cycles.
  - EXEC has mar_sel=1, mar_load=1.
  - MEM has mem_rd=1, acc_load=1, alu_op=00.
  - pc_ctrl=01 is asserted exactly twice.
- JZ with zero=0, then JZ with zero=1 -> EXEC pc_ctrl=00 for the first and 10 for the second; each takes 6 cycles.
- STORE with mem_ready low for 3 cycles in MEM -> mem_wr held 4 cycles; instr_done on the 4th; instruction takes 10 cycles; mem_rd=0 throughout MEM.
- mem_ready held 0 in FETCH_R -> after WAIT_LIMIT+1=16 cycles bus_err=1 and halted=1, ir_load never asserted. Then rst=1 -> all flags clear and FETCH_A is re-entered.
- Opcode 0x9 -> illegal=1 and halted=1 three cycles after fetch start. Opcode 0xF -> halted=1 with illegal=0. No strobes are asserted afterwards.
